// File: rtl/i2c_pkg.sv
// Shared definitions for the MT9V034-style I2C target: FSM states, ACK levels, default address.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    localparam logic [6:0] MT9V034_DEV_ADDR = 7'h48;

    // Level on SDA during the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WR_MSB,
        ST_WR_MSB_ACK,
        ST_WR_LSB,
        ST_WR_LSB_ACK,
        ST_RD_MSB,
        ST_RD_MSB_ACK,
        ST_RD_LSB,
        ST_RD_LSB_ACK,
        ST_WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_mt9v034_slave_if.sv
// Bus bundle between the I2C target and its environment: pin levels, open-drain SDA enable,
// and the register-bank strobe/address/data port. Latency: n/a (wires only).
// Backpressure: none; the register bank must answer rd_data combinationally for rd_addr.
interface i2c_mt9v034_slave_if;

    logic        scl_in;   // SCL pin level
    logic        sda_in;   // SDA pin level
    logic        sda_oe;   // 1 = pull SDA low
    logic        wr_en;    // one-clk write strobe
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;    // one-clk read strobe, rd_data sampled this cycle
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;     // addressed transaction in progress

    modport slave (
        input  scl_in, sda_in, rd_data,
        output sda_oe, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy
    );

    modport master (
        output scl_in, sda_in, rd_data,
        input  sda_oe, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy
    );

endinterface

// File: rtl/i2c_in_filter.sv
// SCL/SDA conditioner: 2-flop synchronizer, stability filter, SCL edge and START/STOP detection.
// Latency: pin change to event pulse is 2 + FILTER_LEN clk.
// Backpressure: none; events are single-cycle pulses that must be consumed when presented.
// Ports: scl_raw/sda_raw pin levels in; sda_lvl filtered SDA; scl_rise/scl_fall/start/stop pulses.
module i2c_in_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    // Bit 0 = SCL, bit 1 = SDA. Idle bus is high, so everything resets to 1.
    logic [1:0]    meta;
    logic [1:0]    sync;
    logic [1:0]    filt;
    logic [1:0]    filt_d;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 2'b11;
            sync   <= 2'b11;
            filt_d <= 2'b11;
        end else begin
            meta   <= {sda_raw, scl_raw};
            sync   <= meta;
            filt_d <= filt;
        end
    end

    // A new level is accepted only after it has been seen FILTER_LEN cycles in a row;
    // any bounce back to the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign sda_lvl  = filt[1];
    assign scl_rise =  filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] &  filt_d[0];
    // SDA edges only count as START/STOP when SCL was and still is high
    assign start    = filt_d[1] & ~filt[1] & filt[0] & filt_d[0];
    assign stop     = ~filt_d[1] & filt[1] & filt[0] & filt_d[0];

endmodule

// File: rtl/i2c_mt9v034_slave.sv
// MT9V034-style I2C register target: 7-bit address, 8-bit register pointer, 16-bit big-endian data.
// Latency: sda_oe 1 clk after detected SCL fall; wr_en 1 clk after LSB bit-0 rise; rd_en on the SCL-fall event.
// Backpressure: none (no clock stretching); rd_data must be valid combinationally for rd_addr.
// Ports: clk, rst_n (async active-low), bus (slave modport: pins, sda_oe, wr_*/rd_* register port, busy).
module i2c_mt9v034_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = MT9V034_DEV_ADDR,
    parameter int         FILTER_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    i2c_mt9v034_slave_if.slave     bus
);

    logic ev_rise;
    logic ev_fall;
    logic ev_start;
    logic ev_stop;
    logic sda_lvl;

    i2c_in_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_in_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_raw  (bus.scl_in),
        .sda_raw  (bus.sda_in),
        .sda_lvl  (sda_lvl),
        .scl_rise (ev_rise),
        .scl_fall (ev_fall),
        .start    (ev_start),
        .stop     (ev_stop)
    );

    state_t      state,     state_nxt;
    logic [3:0]  cnt,       cnt_nxt;        // SCL rises seen in the current byte (0..8)
    logic [7:0]  shift,     shift_nxt;      // incoming byte
    logic [7:0]  msb,       msb_nxt;        // held MSB of a write word
    logic [7:0]  ptr,       ptr_nxt;        // register address pointer
    logic [15:0] rd_sh,     rd_sh_nxt;      // outgoing word, bit 15 is on the wire
    logic        mack,      mack_nxt;       // master ACK sampled after a read LSB
    logic        sda_oe_q,  sda_oe_nxt;
    logic        wr_en_q,   wr_en_nxt;
    logic [7:0]  wr_addr_q, wr_addr_nxt;
    logic [15:0] wr_data_q, wr_data_nxt;
    logic        rd_en_c;
    logic        load_word;
    logic        next_bit;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shift_nxt   = shift;
        msb_nxt     = msb;
        ptr_nxt     = ptr;
        rd_sh_nxt   = rd_sh;
        mack_nxt    = mack;
        sda_oe_nxt  = sda_oe_q;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_q;
        wr_data_nxt = wr_data_q;
        rd_en_c     = 1'b0;
        load_word   = 1'b0;
        next_bit    = 1'b0;

        // STOP wins over everything, including an ACK that is about to be driven
        if (ev_stop) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
        end else if (ev_start) begin
            state_nxt  = ST_DEV;
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
        end else if (ev_rise) begin
            case (state)
                ST_DEV, ST_REG, ST_WR_MSB, ST_WR_LSB: begin
                    shift_nxt = {shift[6:0], sda_lvl};
                    cnt_nxt   = cnt + 4'd1;
                    // Word is complete on the 8th LSB bit; the ACK clock that follows
                    // does not have to happen for the write to land.
                    if (state == ST_WR_LSB && cnt == 4'd7) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = ptr;
                        wr_data_nxt = {msb, shift[6:0], sda_lvl};
                        ptr_nxt     = ptr + 8'd1;
                    end
                end
                ST_RD_MSB, ST_RD_LSB: begin
                    cnt_nxt = cnt + 4'd1;
                end
                ST_RD_LSB_ACK: begin
                    mack_nxt = sda_lvl;
                end
                default: ;
            endcase
        end else if (ev_fall) begin
            case (state)
                ST_DEV: begin
                    if (cnt == 4'd8) begin
                        cnt_nxt = '0;
                        if (shift[7:1] == DEV_ADDR) begin
                            state_nxt  = ST_DEV_ACK;
                            sda_oe_nxt = 1'b1;
                        end else begin
                            state_nxt  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (shift[0]) begin
                        load_word = 1'b1;
                    end else begin
                        state_nxt  = ST_REG;
                        sda_oe_nxt = 1'b0;
                    end
                end
                ST_REG: begin
                    if (cnt == 4'd8) begin
                        ptr_nxt    = shift;
                        state_nxt  = ST_REG_ACK;
                        sda_oe_nxt = 1'b1;
                        cnt_nxt    = '0;
                    end
                end
                ST_REG_ACK: begin
                    state_nxt  = ST_WR_MSB;
                    sda_oe_nxt = 1'b0;
                end
                ST_WR_MSB: begin
                    if (cnt == 4'd8) begin
                        msb_nxt    = shift;
                        state_nxt  = ST_WR_MSB_ACK;
                        sda_oe_nxt = 1'b1;
                        cnt_nxt    = '0;
                    end
                end
                ST_WR_MSB_ACK: begin
                    state_nxt  = ST_WR_LSB;
                    sda_oe_nxt = 1'b0;
                end
                ST_WR_LSB: begin
                    if (cnt == 4'd8) begin
                        state_nxt  = ST_WR_LSB_ACK;
                        sda_oe_nxt = 1'b1;
                        cnt_nxt    = '0;
                    end
                end
                ST_WR_LSB_ACK: begin
                    state_nxt  = ST_WR_MSB;
                    sda_oe_nxt = 1'b0;
                end
                ST_RD_MSB: begin
                    if (cnt == 4'd8) begin
                        state_nxt  = ST_RD_MSB_ACK;
                        sda_oe_nxt = 1'b0;
                        cnt_nxt    = '0;
                    end else if (cnt != 4'd0) begin
                        next_bit = 1'b1;
                    end
                end
                ST_RD_MSB_ACK: begin
                    // Master ACK after the MSB is ignored; always continue with the LSB
                    state_nxt = ST_RD_LSB;
                    cnt_nxt   = '0;
                    next_bit  = 1'b1;
                end
                ST_RD_LSB: begin
                    if (cnt == 4'd8) begin
                        state_nxt  = ST_RD_LSB_ACK;
                        sda_oe_nxt = 1'b0;
                        cnt_nxt    = '0;
                    end else if (cnt != 4'd0) begin
                        next_bit = 1'b1;
                    end
                end
                ST_RD_LSB_ACK: begin
                    if (mack == ACK) begin
                        load_word = 1'b1;
                    end else begin
                        state_nxt  = ST_WAIT_STOP;
                        sda_oe_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Fetch a new word from the bank and put its bit 15 on the wire
        if (load_word) begin
            rd_en_c    = 1'b1;
            rd_sh_nxt  = bus.rd_data;
            sda_oe_nxt = ~bus.rd_data[15];
            ptr_nxt    = ptr + 8'd1;
            cnt_nxt    = '0;
            state_nxt  = ST_RD_MSB;
        end

        // Advance the outgoing word by one bit
        if (next_bit) begin
            rd_sh_nxt  = {rd_sh[14:0], 1'b0};
            sda_oe_nxt = ~rd_sh[14];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shift     <= '0;
            msb       <= '0;
            ptr       <= '0;
            rd_sh     <= '0;
            mack      <= NACK;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shift     <= shift_nxt;
            msb       <= msb_nxt;
            ptr       <= ptr_nxt;
            rd_sh     <= rd_sh_nxt;
            mack      <= mack_nxt;
            sda_oe_q  <= sda_oe_nxt;
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_data_q <= wr_data_nxt;
        end
    end

    assign bus.sda_oe  = sda_oe_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_en   = rd_en_c;
    // The pointer only moves on REG capture, a write word, or rd_en, so it is stable between reads
    assign bus.rd_addr = ptr;
    assign bus.busy    = !(state == ST_IDLE || state == ST_DEV || state == ST_WAIT_STOP);

endmodule

// File: tb/tb_i2c_mt9v034_slave.sv
// Bench for the MT9V034-style I2C target: bit-banged master, register bank model,
// and strobe monitors that pop expected writes/reads from queues.
module tb_i2c_mt9v034_slave;

    localparam int Q = 10;   // clk cycles per SCL quarter-phase step

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    i2c_mt9v034_slave_if bus();

    logic [15:0] mem [256];

    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_m & ~bus.sda_oe;     // open-drain wired-AND
    assign bus.rd_data = mem[bus.rd_addr];

    i2c_mt9v034_slave #(
        .DEV_ADDR   (7'h48),
        .FILTER_LEN (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] exp_wr_q [$];   // {addr, data}
    logic [7:0]  exp_rd_q [$];   // rd_addr

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic oe_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            if (exp_wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_wr: addr 0x%0h data 0x%0h, expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                check("wr_strobe", {8'h00, bus.wr_addr, bus.wr_data}, {8'h00, exp_wr_q.pop_front()});
            end
            mem[bus.wr_addr] = bus.wr_data;
        end
        if (rst_n && bus.rd_en) begin
            if (exp_rd_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rd: addr 0x%0h, expected no read", bus.rd_addr);
            end else begin
                check("rd_strobe", {24'h0, bus.rd_addr}, {24'h0, exp_rd_q.pop_front()});
            end
        end
        // SDA drive may only move while SCL is low
        if (bus.sda_oe !== oe_prev) begin
            if (rst_n) check("oe_change_scl_low", {31'h0, scl_m}, 32'h0);
            oe_prev = bus.sda_oe;
        end
    end

    // ---------------- master tasks ----------------
    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic hq();
        repeat (Q / 2) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            sda_m = 1'b1; wq();
            scl_m = 1'b1; wq();
        end
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic got;
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wq();
            scl_m = 1'b1; wq();
            scl_m = 1'b0;
        end
        sda_m = 1'b1; wq();
        scl_m = 1'b1; hq();
        got = bus.sda_in; hq();
        scl_m = 1'b0; wq();
        check(name, {31'h0, got}, {31'h0, exp_ack});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic m_ack, input string name);
        logic [7:0] got;
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wq();
            scl_m = 1'b1; hq();
            got[i] = bus.sda_in; hq();
            scl_m = 1'b0;
        end
        wq();
        sda_m = m_ack; wq();
        scl_m = 1'b1; wq();
        scl_m = 1'b0; wq();
        check(name, {24'h0, got}, {24'h0, exp});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1324;
        mem[8'h20] = 16'h00FF;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_sda_oe",  {31'h0, bus.sda_oe}, 32'h0);
        check("rst_wr_en",   {31'h0, bus.wr_en}, 32'h0);
        check("rst_rd_en",   {31'h0, bus.rd_en}, 32'h0);
        check("rst_busy",    {31'h0, bus.busy}, 32'h0);
        check("rst_wr_addr", {24'h0, bus.wr_addr}, 32'h0);
        check("rst_wr_data", {16'h0, bus.wr_data}, 32'h0);
        check("rst_rd_addr", {24'h0, bus.rd_addr}, 32'h0);
        rst_n = 1'b1;
        wq();

        // Single write: 0x0C <= 0x0001
        exp_wr_q.push_back({8'h0C, 16'h0001});
        i2c_start();
        write_byte(8'h90, 1'b0, "wr1_ack_dev");
        check("wr1_busy", {31'h0, bus.busy}, 32'h1);
        write_byte(8'h0C, 1'b0, "wr1_ack_reg");
        write_byte(8'h00, 1'b0, "wr1_ack_msb");
        write_byte(8'h01, 1'b0, "wr1_ack_lsb");
        i2c_stop();
        check("wr1_idle_busy", {31'h0, bus.busy}, 32'h0);

        // Burst write across the pointer wrap
        exp_wr_q.push_back({8'hFE, 16'hBEEF});
        exp_wr_q.push_back({8'hFF, 16'h1234});
        i2c_start();
        write_byte(8'h90, 1'b0, "burst_ack_dev");
        write_byte(8'hFE, 1'b0, "burst_ack_reg");
        write_byte(8'hBE, 1'b0, "burst_ack_b0");
        write_byte(8'hEF, 1'b0, "burst_ack_b1");
        write_byte(8'h12, 1'b0, "burst_ack_b2");
        write_byte(8'h34, 1'b0, "burst_ack_b3");
        i2c_stop();
        check("burst_ptr_wrap", {24'h0, bus.rd_addr}, 32'h0);

        // Read with repeated START from 0x00 (bank holds 0x1324)
        i2c_start();
        write_byte(8'h90, 1'b0, "rd_ack_dev_w");
        write_byte(8'h00, 1'b0, "rd_ack_reg");
        exp_rd_q.push_back(8'h00);
        i2c_start();
        write_byte(8'h91, 1'b0, "rd_ack_dev_r");
        read_byte(8'h13, 1'b0, "rd_byte_msb");
        read_byte(8'h24, 1'b1, "rd_byte_lsb");
        i2c_stop();

        // Address mismatch: nobody answers, nothing strobes
        i2c_start();
        write_byte(8'hA0, 1'b1, "miss_nack_dev");
        check("miss_busy", {31'h0, bus.busy}, 32'h0);
        write_byte(8'h00, 1'b1, "miss_nack_data");
        check("miss_sda_oe", {31'h0, bus.sda_oe}, 32'h0);
        i2c_stop();

        // Aborted write (MSB only), then a complete write to 0x0F
        i2c_start();
        write_byte(8'h90, 1'b0, "abort_ack_dev");
        write_byte(8'h0D, 1'b0, "abort_ack_reg");
        write_byte(8'h00, 1'b0, "abort_ack_msb");
        i2c_stop();
        exp_wr_q.push_back({8'h0F, 16'h0001});
        i2c_start();
        write_byte(8'h90, 1'b0, "wr2_ack_dev");
        write_byte(8'h0F, 1'b0, "wr2_ack_reg");
        write_byte(8'h00, 1'b0, "wr2_ack_msb");
        write_byte(8'h01, 1'b0, "wr2_ack_lsb");
        i2c_stop();

        // Reset while the target is driving a 0 data bit
        i2c_start();
        write_byte(8'h90, 1'b0, "rst_rd_ack_dev_w");
        write_byte(8'h20, 1'b0, "rst_rd_ack_reg");
        exp_rd_q.push_back(8'h20);
        i2c_start();
        write_byte(8'h91, 1'b0, "rst_rd_ack_dev_r");
        check("rst_rd_driving", {31'h0, bus.sda_oe}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async_release", {31'h0, bus.sda_oe}, 32'h0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_mid_ptr", {24'h0, bus.rd_addr}, 32'h0);
        rst_n = 1'b1;
        wq();

        // After reset: write 0x10 <= 0xA5A5, then burst-read 0x0F..0x10
        exp_wr_q.push_back({8'h10, 16'hA5A5});
        i2c_start();
        write_byte(8'h90, 1'b0, "wr3_ack_dev");
        write_byte(8'h10, 1'b0, "wr3_ack_reg");
        write_byte(8'hA5, 1'b0, "wr3_ack_msb");
        write_byte(8'hA5, 1'b0, "wr3_ack_lsb");
        i2c_stop();

        i2c_start();
        write_byte(8'h90, 1'b0, "brd_ack_dev_w");
        write_byte(8'h0F, 1'b0, "brd_ack_reg");
        exp_rd_q.push_back(8'h0F);
        exp_rd_q.push_back(8'h10);
        i2c_start();
        write_byte(8'h91, 1'b0, "brd_ack_dev_r");
        read_byte(8'h00, 1'b0, "brd_w0_msb");
        read_byte(8'h01, 1'b0, "brd_w0_lsb");
        read_byte(8'hA5, 1'b0, "brd_w1_msb");
        read_byte(8'hA5, 1'b1, "brd_w1_lsb");
        i2c_stop();
        check("brd_idle_busy", {31'h0, bus.busy}, 32'h0);

        wq();
        check("wr_queue_drained", exp_wr_q.size(), 32'h0);
        check("rd_queue_drained", exp_rd_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
